packet_receiver: RTL

- UART receive path from the FTDI link (ftdi_rx); the counterpart of packet_sender on the inbound side.
- Deserialises 8N1 bytes and assembles PACKET_SIZE consecutive bytes into one wide packet word.
- Presents the packet with a one-cycle valid pulse to downstream compute logic, e.g. the FFT input buffer.
- Detects framing errors and inter-byte timeouts, and discards any partial packet when either occurs.

---
 rtl/uart_defs_pkg.sv | 16 +
 rtl/uart_rx_byte.sv | 98 +++++++++
 rtl/packet_receiver.sv | 96 +++++++++
 3 files changed

// File: rtl/uart_defs_pkg.sv
// UART constants and rx FSM encoding, shared by packet_receiver and packet_sender.
package uart_defs;

  localparam int CLK_FREQ_HZ  = 12000000;
  localparam int DEFAULT_BAUD = 115200;
  // Truncating division gives 104 for 12 MHz / 115200.
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / DEFAULT_BAUD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 deserialiser: byte_strobe/frame_err pulse one cycle after the mid-stop-bit sample.
// No backpressure: the consumer must take the byte on byte_strobe.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = uart_defs::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_err,
  output logic       in_flight
);
  import uart_defs::*;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q, sync_d;
  rx_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          strobe_q, strobe_d;
  logic          ferr_q, ferr_d;
  logic          rxs;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    sync_d    = {sync_q[0], rxd};
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (timer_q == HALF_M1) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d   = '0;
          data_d    = {rxs, data_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a start edge half a bit later is still caught.
        if (timer_q == FULL_M1) begin
          timer_d  = '0;
          state_d  = IDLE;
          strobe_d = rxs;
          ferr_d   = !rxs;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte     = data_q;
  assign byte_strobe = strobe_q;
  assign frame_err   = ferr_q;
  // Includes the IDLE cycle that detects the start edge, so START entry is visible here.
  assign in_flight   = (state_q != IDLE) || !rxs;

endmodule

// File: rtl/packet_receiver.sv
// Assembles PACKET_SIZE UART bytes into one word; valid pulses two cycles after the last stop sample.
// No backpressure: packet holds until the next complete packet, partial packets dropped on error/timeout.
module packet_receiver #(
  parameter int          CLKS_PER_BIT = uart_defs::CLKS_PER_BIT,
  parameter logic [15:0] PACKET_SIZE  = 16'd15,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rxd,
  output logic [8*PACKET_SIZE-1:0] packet,
  output logic                     valid,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     timeout_err
);
  import uart_defs::*;

  localparam int PW        = 8 * int'(PACKET_SIZE);
  localparam int GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);
  localparam logic [GW-1:0] GAP_TERM = GW'(GAP_LIMIT - 1);

  logic [7:0]    rx_byte;
  logic          byte_strobe;
  logic          in_flight;

  logic [PW-1:0] shreg_q, shreg_d;
  logic [PW-1:0] packet_q, packet_d;
  logic [15:0]   count_q, count_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          valid_q, valid_d;
  logic          tout_q, tout_d;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .rx_byte     (rx_byte),
    .byte_strobe (byte_strobe),
    .frame_err   (frame_err),
    .in_flight   (in_flight)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      packet_q <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      packet_q <= packet_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
    end
  end

  always_comb begin
    shreg_d  = shreg_q;
    packet_d = packet_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    tout_d   = 1'b0;
    gap_d    = (in_flight || count_q == 16'd0) ? '0 : gap_q + 1'b1;
    if (byte_strobe) begin
      shreg_d = {shreg_q[PW-9:0], rx_byte};
      if (count_q == PACKET_SIZE - 16'd1) begin
        packet_d = shreg_d;
        valid_d  = 1'b1;
        count_d  = '0;
      end else begin
        count_d = count_q + 16'd1;
      end
    end else if (frame_err) begin
      count_d = '0;
    end else if (!in_flight && count_q != 16'd0 && gap_q == GAP_TERM) begin
      // in_flight covers START entry, so a coincident start edge suppresses the timeout.
      count_d = '0;
      gap_d   = '0;
      tout_d  = 1'b1;
    end
  end

  assign packet      = packet_q;
  assign valid       = valid_q;
  assign timeout_err = tout_q;
  assign busy        = (count_q != 16'd0) || in_flight || byte_strobe;

endmodule
